// File: rtl/isa_bus_sequencer.sv
// isa_bus_sequencer: drives one ISA I/O read or write cycle per go edge with programmable setup/strobe/hold timing.
module isa_bus_sequencer #(
    parameter int SETUP_CYCLES   = 2,
    parameter int STROBE_CYCLES  = 10,
    parameter int HOLD_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  control_in,
    input  logic [15:0] address_in,
    input  logic [15:0] data_in,
    input  logic [15:0] isa_data_in,
    input  logic        isa_iochrdy,
    output logic [15:0] isa_addr,
    output logic [15:0] isa_data_out,
    output logic        isa_data_oe,
    output logic        isa_ior_n,
    output logic        isa_iow_n,
    output logic [15:0] read_data,
    output logic        read_load,
    output logic        control_reset,
    output logic        busy,
    output logic        timeout
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT_RDY, HOLD, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, addr_q, addr_d, data_q, data_d, rdata_q, rdata_d;
    logic        dir_q, dir_d, go_prev_q, timeout_q, timeout_d, load_q, load_d;
    logic        go_edge, strobing, ctrl_unused;

    assign ctrl_unused = ^control_in[7:2];
    assign go_edge     = control_in[0] & ~go_prev_q;
    assign strobing    = (state_q == STROBE) || (state_q == WAIT_RDY);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 16'd1;
        addr_d    = addr_q;
        data_d    = data_q;
        dir_d     = dir_q;
        timeout_d = timeout_q;
        rdata_d   = rdata_q;
        load_d    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (go_edge) begin
                    state_d   = SETUP;
                    addr_d    = address_in;
                    data_d    = data_in;
                    dir_d     = control_in[1];
                    timeout_d = 1'b0;
                end
            end
            SETUP: if (cnt_q == 16'(SETUP_CYCLES - 1)) begin
                state_d = STROBE;
                cnt_d   = '0;
            end
            STROBE: if (cnt_q == 16'(STROBE_CYCLES - 1)) begin
                state_d = isa_iochrdy ? HOLD : WAIT_RDY;
                cnt_d   = '0;
            end
            // cnt counts consecutive not-ready cycles; any ready cycle exits
            WAIT_RDY: if (isa_iochrdy) begin
                state_d = HOLD;
                cnt_d   = '0;
            end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                state_d   = HOLD;
                cnt_d     = '0;
                timeout_d = 1'b1;
            end
            HOLD: if (cnt_q == 16'(HOLD_CYCLES - 1)) begin
                state_d = DONE;
                cnt_d   = '0;
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
        if (dir_q && strobing && state_d == HOLD && isa_iochrdy) begin
            rdata_d = isa_data_in;
            load_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            dir_q     <= 1'b0;
            rdata_q   <= '0;
            load_q    <= 1'b0;
            timeout_q <= 1'b0;
            go_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            dir_q     <= dir_d;
            rdata_q   <= rdata_d;
            load_q    <= load_d;
            timeout_q <= timeout_d;
            go_prev_q <= control_in[0];
        end
    end

    assign isa_addr      = addr_q;
    assign isa_data_out  = data_q;
    assign isa_data_oe   = ~dir_q && (state_q == SETUP || strobing || state_q == HOLD);
    assign isa_ior_n     = ~(dir_q & strobing);
    assign isa_iow_n     = ~(~dir_q & strobing);
    assign read_data     = rdata_q;
    assign read_load     = load_q;
    assign control_reset = state_q == DONE;
    assign busy          = state_q != IDLE;
    assign timeout       = timeout_q;
endmodule

// File: doc/isa_bus_sequencer.md
ISA_BUS_SEQUENCER -- requirements
Module: isa_bus_sequencer

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 2, address/data setup before strobe (range 1-15).
REQ-002 SHALL have parameter STROBE_CYCLES, default 10, minimum strobe width (range 1-63).
REQ-003 SHALL have parameter HOLD_CYCLES, default 2, address/data hold after strobe (range 1-15).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum IOCHRDY wait (range 1-65535).
REQ-005 SHALL have one clock and an asynchronous active-high reset: clk input 1, reset input 1.
REQ-006 control_in input 8 -- control register; bit0 go, bit1 dir (1=read, 0=write).
REQ-007 address_in input 16 -- target I/O address from address register.
REQ-008 data_in input 16 -- write data from data register.
REQ-009 isa_data_in input 16 -- ISA data bus sampled on reads.
REQ-010 isa_iochrdy input 1 -- ISA ready; 0 inserts wait states.
REQ-011 isa_addr output 16 -- ISA address.
REQ-012 isa_data_out output 16, isa_data_oe output 1 -- write data and its drive enable.
REQ-013 isa_ior_n output 1, isa_iow_n output 1 -- active-low I/O strobes.
REQ-014 read_data output 16, read_load output 1 -- captured read data and one-cycle load pulse to data register.
REQ-015 control_reset output 1 -- one-cycle pulse clearing the control register on completion.
REQ-016 busy output 1, timeout output 1 -- cycle in progress; sticky timeout flag.

Function
REQ-017 Start SHALL be the rising edge of control_in[0] (registered previous value); level-held go SHALL NOT retrigger.
REQ-018 States SHALL be IDLE, SETUP, STROBE, WAIT_RDY, HOLD, DONE.
REQ-019 IDLE: on go edge, latch address_in, data_in, dir; next state SETUP; timeout cleared.
REQ-020 go edge while not IDLE SHALL be ignored, not queued.
REQ-021 SETUP: isa_addr = latched address; isa_data_oe=1 only for write; strobes high; lasts SETUP_CYCLES.
REQ-022 STROBE: isa_ior_n=0 (read) or isa_iow_n=0 (write), never both; lasts STROBE_CYCLES.
REQ-023 Last STROBE cycle: isa_iochrdy=1 -> HOLD; else WAIT_RDY with strobe held.
REQ-024 WAIT_RDY: isa_iochrdy sampled 1 -> HOLD; TIMEOUT_CYCLES consecutive cycles at 0 -> set timeout, HOLD.
REQ-025 Read: isa_data_in captured into read_data on the clock edge leaving STROBE/WAIT_RDY with ready=1; read_load pulses 1 cycle in the first HOLD cycle; no capture or pulse on timeout.
REQ-026 HOLD: strobes high; isa_addr and isa_data_oe unchanged; lasts HOLD_CYCLES.
REQ-027 DONE: one cycle, control_reset=1, isa_data_oe=0; then IDLE.
REQ-028 busy SHALL be 1 in every state except IDLE; zero-wait cycle busy length = SETUP+STROBE+HOLD+1 (15 with defaults).
REQ-029 timeout SHALL stay set until next go edge or reset.
REQ-030 Write cycles SHALL NOT alter read_data.

Reset
REQ-031 reset SHALL immediately (asynchronously) force IDLE, isa_ior_n=1, isa_iow_n=1, isa_data_oe=0, isa_addr=0, isa_data_out=0, read_data=0, read_load=0, control_reset=0, busy=0, timeout=0.
REQ-032 Previous-go register SHALL reset to 1, so go held high across reset release does not start a cycle.
REQ-033 Reset mid-cycle SHALL abort without control_reset or read_load pulse.

Verification
REQ-034 Write addr 0x0220 data 0x00A5, iochrdy=1 -> iow_n low exactly 10 cycles, oe=1 for 14 cycles, busy 15 cycles, one control_reset pulse, ior_n stays 1.
REQ-035 Read addr 0x022A, isa_data_in=0xBEEF, iochrdy=1 -> ior_n low 10 cycles, read_data=0xBEEF, one read_load pulse, oe never 1.
REQ-036 Read with iochrdy=0 for 5 cycles after strobe minimum -> ior_n low 15 cycles, capture data present when iochrdy rises, timeout=0.
REQ-037 iochrdy held 0 -> timeout=1 after 1024 WAIT_RDY cycles, no read_load, control_reset pulses, read_data unchanged.
REQ-038 Reset asserted in STROBE -> strobes high and busy=0 same cycle, no control_reset; go held 1 through release -> no new cycle.
REQ-039 Second go edge during busy -> exactly one bus cycle performed.
